// File: rtl/player_hit_collector_pkg.sv
// Shared game types and constants for the player hit collector.
package player_hit_collector_pkg;

  typedef enum logic [1:0] {
    ALIVE    = 2'd0,
    COOLDOWN = 2'd1,
    DEAD     = 2'd2
  } player_state_t;

  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  localparam int unsigned EDGE_W = 4;
  localparam int unsigned CD_W   = 8;

endpackage

// File: rtl/frame_overlap_accum.sv
// Per-frame accumulation of player/block edge overlaps and player/shot hits,
// published at every frame boundary.
module frame_overlap_accum
  import player_hit_collector_pkg::*;
#(
  parameter int unsigned NUM_SHOTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sof_i,
  input  logic                 player_i,
  input  logic [EDGE_W-1:0]    edge_i,
  input  logic                 block_i,
  input  logic [NUM_SHOTS-1:0] shot_i,
  output logic [EDGE_W-1:0]    block_edges_o,
  output logic [NUM_SHOTS-1:0] shot_hit_mask_o,
  output logic                 hit_acc_o
);

  logic [EDGE_W-1:0]    edge_c;
  logic [NUM_SHOTS-1:0] shot_c;
  logic [EDGE_W-1:0]    edge_acc_q, edge_acc_d;
  logic [NUM_SHOTS-1:0] shot_acc_q, shot_acc_d;
  logic                 hit_acc_q, hit_acc_d;
  logic [EDGE_W-1:0]    block_edges_q, block_edges_d;
  logic [NUM_SHOTS-1:0] shot_mask_q, shot_mask_d;

  // This pixel's own contribution; HitEdgeCode only matters on player pixels.
  assign edge_c = (player_i && block_i) ? edge_i : '0;
  assign shot_c = player_i ? shot_i : '0;

  // The boundary pixel belongs to the new frame, so accumulators reload with it.
  always_comb begin
    block_edges_d = block_edges_q;
    shot_mask_d   = shot_mask_q;
    edge_acc_d    = edge_acc_q | edge_c;
    shot_acc_d    = shot_acc_q | shot_c;
    hit_acc_d     = hit_acc_q | (|shot_c);
    if (sof_i) begin
      block_edges_d = edge_acc_q;
      shot_mask_d   = shot_acc_q;
      edge_acc_d    = edge_c;
      shot_acc_d    = shot_c;
      hit_acc_d     = |shot_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_acc_q    <= '0;
      shot_acc_q    <= '0;
      hit_acc_q     <= 1'b0;
      block_edges_q <= '0;
      shot_mask_q   <= '0;
    end else begin
      edge_acc_q    <= edge_acc_d;
      shot_acc_q    <= shot_acc_d;
      hit_acc_q     <= hit_acc_d;
      block_edges_q <= block_edges_d;
      shot_mask_q   <= shot_mask_d;
    end
  end

  assign block_edges_o   = block_edges_q;
  assign shot_hit_mask_o = shot_mask_q;
  assign hit_acc_o       = hit_acc_q;

endmodule

// File: rtl/player_hit_collector.sv
// Player hit collector: per-frame overlap publishing plus the lives /
// invulnerability state machine, advanced once per frame.
module player_hit_collector
  import player_hit_collector_pkg::*;
#(
  parameter int unsigned NUM_SHOTS       = 4,
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned LIVES_W         = 2,
  parameter int unsigned COOLDOWN_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 drawingRequestPlayer,
  input  logic [EDGE_W-1:0]    HitEdgeCode,
  input  logic                 drawingRequestBlock,
  input  logic [NUM_SHOTS-1:0] drawingRequestShot,
  output logic [EDGE_W-1:0]    blockEdges,
  output logic                 playerHit,
  output logic [NUM_SHOTS-1:0] shotHitMask,
  output logic [LIVES_W-1:0]   livesLeft,
  output logic                 invulnerable,
  output logic                 gameOver
);

  logic hit_acc;

  player_state_t      state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic               hit_q, hit_d;
  logic               inv_q, inv_d;
  logic               over_q, over_d;

  frame_overlap_accum #(
    .NUM_SHOTS(NUM_SHOTS)
  ) u_accum (
    .clk            (clk),
    .reset          (reset),
    .sof_i          (startOfFrame),
    .player_i       (drawingRequestPlayer),
    .edge_i         (HitEdgeCode),
    .block_i        (drawingRequestBlock),
    .shot_i         (drawingRequestShot),
    .block_edges_o  (blockEdges),
    .shot_hit_mask_o(shotHitMask),
    .hit_acc_o      (hit_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ALIVE;
      lives_q  <= LIVES_W'(LIVES_INIT);
      cd_cnt_q <= '0;
      hit_q    <= 1'b0;
      inv_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      cd_cnt_q <= cd_cnt_d;
      hit_q    <= hit_d;
      inv_q    <= inv_d;
      over_q   <= over_d;
    end
  end

  // Transitions happen only at the frame boundary, judged on the ending frame.
  always_comb begin
    state_d = state_q;
    if (startOfFrame) begin
      unique case (state_q)
        ALIVE: begin
          if (hit_acc) begin
            state_d = (lives_q == LIVES_W'(1)) ? DEAD : COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cd_cnt_q == '0) begin
            state_d = ALIVE;
          end
        end
        DEAD:    state_d = DEAD;
        default: state_d = ALIVE;
      endcase
    end
  end

  always_comb begin
    lives_d  = lives_q;
    cd_cnt_d = cd_cnt_q;
    hit_d    = 1'b0;
    if (startOfFrame) begin
      if (state_q == ALIVE && hit_acc && lives_q != '0) begin
        hit_d    = 1'b1;
        lives_d  = lives_q - LIVES_W'(1);
        cd_cnt_d = CD_W'(COOLDOWN_FRAMES - 1);
      end else if (state_q == COOLDOWN && cd_cnt_q != '0) begin
        cd_cnt_d = cd_cnt_q - CD_W'(1);
      end
    end
    inv_d  = (state_d == COOLDOWN);
    over_d = (state_d == DEAD);
  end

  assign playerHit    = hit_q;
  assign livesLeft    = lives_q;
  assign invulnerable = inv_q;
  assign gameOver     = over_q;

endmodule

// File: tb/tb_player_hit_collector.sv
// Self-checking bench for player_hit_collector: directed vector table,
// multi-frame corner sequences and randomized traffic against a frame-level model.
module tb_player_hit_collector;

  localparam int CDF = 32;

  logic       clk;
  logic       reset;
  logic       sof;
  logic       player;
  logic [3:0] hec;
  logic       block;
  logic [3:0] shot;
  logic [3:0] blockEdges;
  logic       playerHit;
  logic [3:0] shotHitMask;
  logic [1:0] livesLeft;
  logic       invulnerable;
  logic       gameOver;

  int total = 0;
  int bad   = 0;

  player_hit_collector dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (sof),
    .drawingRequestPlayer(player),
    .HitEdgeCode         (hec),
    .drawingRequestBlock (block),
    .drawingRequestShot  (shot),
    .blockEdges          (blockEdges),
    .playerHit           (playerHit),
    .shotHitMask         (shotHitMask),
    .livesLeft           (livesLeft),
    .invulnerable        (invulnerable),
    .gameOver            (gameOver)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level reference: frames are numbered by the SOFs that close them.
  logic [3:0] m_acc_e, m_acc_s, m_blk, m_mask;
  logic       m_hit;
  int         m_lives, m_last, m_alive_from;

  task automatic model_step(input logic r, input logic s, input logic p,
                            input logic [3:0] e, input logic b, input logic [3:0] sh);
    logic [3:0] ce, cs;
    if (r) begin
      m_acc_e = '0; m_acc_s = '0; m_blk = '0; m_mask = '0; m_hit = 1'b0;
      m_lives = 3; m_last = -1; m_alive_from = -1;
    end else begin
      ce = (p && b) ? e : 4'h0;
      cs = p ? sh : 4'h0;
      m_hit = 1'b0;
      if (s) begin
        m_blk  = m_acc_e;
        m_mask = m_acc_s;
        m_last = m_last + 1;
        if (m_acc_s != 0 && m_lives > 0 && m_last > m_alive_from) begin
          m_lives = m_lives - 1;
          m_hit   = 1'b1;
          m_alive_from = m_last + CDF;
        end
        m_acc_e = ce;
        m_acc_s = cs;
      end else begin
        m_acc_e = m_acc_e | ce;
        m_acc_s = m_acc_s | cs;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic s, input logic p,
                       input logic [3:0] e, input logic b, input logic [3:0] sh);
    reset = r; sof = s; player = p; hec = e; block = b; shot = sh;
    @(posedge clk);
    model_step(r, s, p, e, b, sh);
    #1;
  endtask

  typedef struct {
    logic       rst, s, p;
    logic [3:0] e;
    logic       b;
    logic [3:0] sh;
    logic [3:0] x_blk, x_mask;
    logic       x_hit;
    logic [1:0] x_lives;
    logic       x_inv, x_over;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic s, logic p, logic [3:0] e, logic b,
                              logic [3:0] sh, logic [3:0] xb, logic [3:0] xm,
                              logic xh, logic [1:0] xl, logic xi, logic xo);
    vec_t v;
    v.rst = rst; v.s = s; v.p = p; v.e = e; v.b = b; v.sh = sh;
    v.x_blk = xb; v.x_mask = xm; v.x_hit = xh; v.x_lives = xl; v.x_inv = xi; v.x_over = xo;
    return v;
  endfunction

  int pulse_q[$];
  int stray_pulses;
  int sof_cnt;

  // Frames of 4 pixels where shot[0] overlaps the player on every pixel.
  task automatic run_hit_frames(input int n);
    for (int f = 0; f < n; f++) begin
      apply(1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'b0001);
      if (playerHit) pulse_q.push_back(sof_cnt);
      sof_cnt++;
      for (int c = 0; c < 3; c++) begin
        apply(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0001);
        if (playerHit) stray_pulses++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; sof = 1'b0; player = 1'b0; hec = 4'h0; block = 1'b0; shot = 4'h0;
    model_step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

    // rst sof p  edge b  shot   blk   mask   hit lives inv over
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h8, 1, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h4, 1, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'hC, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 4'hC, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h2, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 0, 4'h9, 4'h2, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h9, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h9, 0, 2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'hF, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 4'h0, 0, 4'h4, 4'h0, 4'h0, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 4'h0, 4'h4, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h4, 0, 2, 1, 0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].s, vecs[i].p, vecs[i].e, vecs[i].b, vecs[i].sh);
      chk($sformatf("vec%0d blockEdges", i), int'(blockEdges), int'(vecs[i].x_blk));
      chk($sformatf("vec%0d shotHitMask", i), int'(shotHitMask), int'(vecs[i].x_mask));
      chk($sformatf("vec%0d playerHit", i), int'(playerHit), int'(vecs[i].x_hit));
      chk($sformatf("vec%0d livesLeft", i), int'(livesLeft), int'(vecs[i].x_lives));
      chk($sformatf("vec%0d invulnerable", i), int'(invulnerable), int'(vecs[i].x_inv));
      chk($sformatf("vec%0d gameOver", i), int'(gameOver), int'(vecs[i].x_over));
    end

    // Continuous hits: lives lost at SOF 1, 34 and 67 only.
    apply(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    pulse_q.delete(); stray_pulses = 0; sof_cnt = 0;
    run_hit_frames(34);
    chk("cd lives after 34 sofs", int'(livesLeft), 2);
    run_hit_frames(1);
    chk("cd lives after 35 sofs", int'(livesLeft), 1);
    chk("cd inv after second hit", int'(invulnerable), 1);
    run_hit_frames(45);
    chk("cd pulse count", pulse_q.size(), 3);
    if (pulse_q.size() == 3) begin
      chk("cd pulse0 sof", pulse_q[0], 1);
      chk("cd pulse1 sof", pulse_q[1], 34);
      chk("cd pulse2 sof", pulse_q[2], 67);
    end
    chk("cd stray pulses", stray_pulses, 0);
    chk("cd final lives", int'(livesLeft), 0);
    chk("cd gameOver", int'(gameOver), 1);
    chk("cd dead not inv", int'(invulnerable), 0);

    // Reset mid-cooldown with one life left, then a partial frame.
    apply(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    sof_cnt = 0;
    run_hit_frames(40);
    chk("rst pre lives", int'(livesLeft), 1);
    chk("rst pre inv", int'(invulnerable), 1);
    apply(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0010);
    apply(1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'b0010);
    chk("rst lives", int'(livesLeft), 3);
    chk("rst inv", int'(invulnerable), 0);
    chk("rst over", int'(gameOver), 0);
    chk("rst hit", int'(playerHit), 0);
    chk("rst blk", int'(blockEdges), 0);
    chk("rst mask", int'(shotHitMask), 0);
    apply(1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 4'h0);
    apply(1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    chk("partial blk", int'(blockEdges), 1);
    chk("partial mask", int'(shotHitMask), 0);
    chk("partial hit", int'(playerHit), 0);

    // Randomized traffic against the reference model.
    apply(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    begin
      int gap;
      gap = 0;
      for (int c = 0; c < 6000; c++) begin
        logic r, s, p, b;
        logic [3:0] e, sh;
        r  = ($urandom_range(0, 999) == 0);
        s  = (gap == 0);
        if (s) gap = $urandom_range(3, 11); else gap--;
        p  = $urandom_range(0, 1) == 1;
        b  = $urandom_range(0, 2) == 0;
        e  = 4'($urandom);
        sh = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
        apply(r, s, p, e, b, sh);
        chk("rnd blockEdges", int'(blockEdges), int'(m_blk));
        chk("rnd shotHitMask", int'(shotHitMask), int'(m_mask));
        chk("rnd playerHit", int'(playerHit), int'(m_hit));
        chk("rnd livesLeft", int'(livesLeft), m_lives);
        chk("rnd invulnerable", int'(invulnerable),
            (m_lives > 0 && m_last < m_alive_from) ? 1 : 0);
        chk("rnd gameOver", int'(gameOver), (m_lives == 0) ? 1 : 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
